rob_param: RTL

Parametrised reorder buffer for the out-of-order core: DEPTH-entry circular queue with count-based full/empty (no wasted slot), WB_PORTS parallel writeback ports from the CDB, and in-order single-entry commit to the register file. Handles stores by a held request/ack to the memory controller, and resolves branch/JALR mispredicts by flushing every younger entry. Sits between the decoder/issue stage (allocation), the reservation stations/ALUs (writeback) and the register file / memory controller (commit).

---
 rtl/rob_param.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Reorder buffer: circular queue with multi-port CDB writeback, in-order commit,
// held store handshake and flush of younger entries on branch/JALR mispredict.
module rob_param #(
  parameter  int DEPTH    = 16,
  parameter  int DATA_W   = 32,
  parameter  int WB_PORTS = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [1:0]                   alloc_kind,
  input  logic [4:0]                   alloc_rd,
  input  logic [DATA_W-1:0]            alloc_pc,
  input  logic                         alloc_pred_taken,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
  input  logic [WB_PORTS-1:0]          wb_taken,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_target,
  input  logic [TAG_W-1:0]             query_tag,
  output logic                         query_done,
  output logic [DATA_W-1:0]            query_value,
  output logic                         commit_valid,
  output logic [4:0]                   commit_rd,
  output logic [DATA_W-1:0]            commit_value,
  output logic [TAG_W-1:0]             commit_tag,
  output logic                         store_req,
  output logic [TAG_W-1:0]             store_tag,
  input  logic                         store_ack,
  output logic                         flush,
  output logic [DATA_W-1:0]            flush_pc,
  output logic [TAG_W:0]               count
);

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  logic [DEPTH-1:0]  busy_q, done_q, pred_q, taken_q;
  kind_e             kind_q   [DEPTH];
  logic [4:0]        rd_q     [DEPTH];
  logic [DATA_W-1:0] pc_q     [DEPTH];
  logic [DATA_W-1:0] value_q  [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    cnt;

  logic [TAG_W-1:0]  wb_tag_a    [WB_PORTS];
  logic [DATA_W-1:0] wb_value_a  [WB_PORTS];
  logic [DATA_W-1:0] wb_target_a [WB_PORTS];

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_unpack
    assign wb_tag_a[p]    = wb_tag[p*TAG_W +: TAG_W];
    assign wb_value_a[p]  = wb_value[p*DATA_W +: DATA_W];
    assign wb_target_a[p] = wb_target[p*DATA_W +: DATA_W];
  end

  logic              head_ready, mispredict, full, do_alloc, pop;
  kind_e             head_kind;
  logic [DATA_W-1:0] head_pc4;

  assign head_ready  = (cnt != '0) && busy_q[head] && done_q[head];
  assign head_kind   = kind_q[head];
  assign head_pc4    = pc_q[head] + DATA_W'(4);
  assign mispredict  = head_ready && ((head_kind == KIND_JALR) ||
                       ((head_kind == KIND_BRANCH) && (taken_q[head] != pred_q[head])));
  assign full        = (cnt == (TAG_W+1)'(DEPTH));
  assign alloc_ready = !full && !mispredict;
  assign do_alloc    = alloc_valid && alloc_ready;
  // A store at the head only leaves once memory has accepted it.
  assign pop         = head_ready && ((head_kind != KIND_STORE) || store_ack);
  assign store_req   = head_ready && (head_kind == KIND_STORE);
  assign store_tag   = head;
  assign alloc_tag   = tail;
  assign count       = cnt;
  assign query_done  = busy_q[query_tag] && done_q[query_tag];
  assign query_value = value_q[query_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      pred_q       <= '0;
      taken_q      <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i]   <= KIND_ALU;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
    end else begin
      commit_valid <= 1'b0;
      flush        <= 1'b0;

      // Later ports are visited last, so the highest index wins on a tag clash.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && busy_q[wb_tag_a[p]]) begin
          done_q[wb_tag_a[p]]   <= 1'b1;
          value_q[wb_tag_a[p]]  <= wb_value_a[p];
          taken_q[wb_tag_a[p]]  <= wb_taken[p];
          target_q[wb_tag_a[p]] <= wb_target_a[p];
        end
      end

      if (pop) begin
        commit_tag   <= head;
        commit_value <= value_q[head];
        commit_rd    <= '0;
        case (head_kind)
          KIND_ALU: begin
            commit_valid <= 1'b1;
            commit_rd    <= rd_q[head];
          end
          KIND_STORE: commit_valid <= 1'b1;
          KIND_BRANCH: begin
            if (mispredict) begin
              flush    <= 1'b1;
              flush_pc <= taken_q[head] ? target_q[head] : head_pc4;
            end else begin
              commit_valid <= 1'b1;
            end
          end
          KIND_JALR: begin
            commit_valid <= 1'b1;
            commit_rd    <= rd_q[head];
            commit_value <= head_pc4;
            flush        <= 1'b1;
            flush_pc     <= target_q[head];
          end
          default: ;
        endcase
      end

      if (mispredict) begin
        head   <= head + TAG_W'(1);
        tail   <= head + TAG_W'(1);
        cnt    <= '0;
        busy_q <= '0;
        done_q <= '0;
      end else begin
        if (pop) begin
          busy_q[head] <= 1'b0;
          done_q[head] <= 1'b0;
          head         <= head + TAG_W'(1);
        end
        if (do_alloc) begin
          busy_q[tail] <= 1'b1;
          done_q[tail] <= 1'b0;
          kind_q[tail] <= kind_e'(alloc_kind);
          rd_q[tail]   <= alloc_rd;
          pc_q[tail]   <= alloc_pc;
          pred_q[tail] <= alloc_pred_taken;
          tail         <= tail + TAG_W'(1);
        end
        cnt <= cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(pop);
      end
    end
  end

endmodule
